// File: rtl/terminal_scroll_controller.sv
// Text-grid terminal controller: debounced button edges plus a glyph code become
// one-cell-per-cycle grid writes, with auto-wrap, circular scrolling, full clear and a status field.
module terminal_scroll_controller #(
  parameter int unsigned SCREEN_WIDTH  = 76,
  parameter int unsigned SCREEN_HEIGHT = 44,
  parameter int unsigned STATUS_ROW    = 42,
  parameter int unsigned STATUS_COL    = 0,
  parameter int unsigned STATUS_LEN    = 8,
  localparam int unsigned TEXT_ROWS    = STATUS_ROW,
  localparam int unsigned ADDR_W       = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  localparam int unsigned ROW_W        = $clog2(TEXT_ROWS),
  localparam int unsigned COL_W        = $clog2(SCREEN_WIDTH)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              char_btn,
  input  logic              enter_btn,
  input  logic              bksp_btn,
  input  logic              clear_btn,
  input  logic [5:0]        char_code,
  input  logic [1:0]        status_mode,
  output logic              tg_we,
  output logic [ADDR_W-1:0] tg_addr,
  output logic [7:0]        tg_input,
  output logic [ROW_W-1:0]  row_offset,
  output logic [COL_W-1:0]  cursor_x,
  output logic [ROW_W-1:0]  cursor_y,
  output logic              busy
);

  localparam int unsigned RSUM_W = ROW_W + 1;
  localparam int unsigned B_CHAR = 0;
  localparam int unsigned B_ENT  = 1;
  localparam int unsigned B_BKSP = 2;
  localparam int unsigned B_CLR  = 3;

  localparam logic [ADDR_W-1:0] STATUS_BASE = ADDR_W'(STATUS_ROW * SCREEN_WIDTH + STATUS_COL);
  localparam logic [ADDR_W-1:0] STATUS_LAST = ADDR_W'(STATUS_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(SCREEN_WIDTH - 1);
  localparam logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(TEXT_ROWS * SCREEN_WIDTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(SCREEN_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(TEXT_ROWS - 1);

  typedef enum logic [1:0] {IDLE, STATUS, CLEAR_LINE, CLEAR_ALL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d, shown_q, shown_d;
  logic [ROW_W-1:0]    line_q, line_d;
  logic [3:0]          btn_q, pend_q, pend_d;
  logic                we_q, we_d, busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [ROW_W-1:0]    off_q, off_d, cy_q, cy_d, ny;
  logic [COL_W-1:0]    cx_q, cx_d, nx;
  logic [3:0]          btns, fall;
  logic                adv;

  // Physical cell address of logical (y, x) under a circular row offset.
  function automatic logic [ADDR_W-1:0] phys(input logic [ROW_W-1:0] y,
                                             input logic [ROW_W-1:0] off,
                                             input logic [COL_W-1:0] x);
    logic [RSUM_W-1:0] r;
    r = {1'b0, y} + {1'b0, off};
    if (r >= RSUM_W'(TEXT_ROWS)) r = r - RSUM_W'(TEXT_ROWS);
    return ADDR_W'(r) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(x);
  endfunction

  function automatic logic [7:0] glyph(input logic [5:0] c);
    logic [7:0] g;
    case (c)
      6'd27:   g = 8'd60;
      6'd28:   g = 8'd62;
      6'd29:   g = 8'd40;
      6'd30:   g = 8'd41;
      6'd31:   g = 8'd61;
      6'd32:   g = 8'd44;
      6'd33:   g = 8'd46;
      6'd34:   g = 8'd35;
      6'd44:   g = 8'd48;
      6'd45:   g = 8'd124;
      6'd46:   g = 8'd38;
      6'd47:   g = 8'd33;
      6'd48:   g = 8'd10;
      default: g = 8'd32;
    endcase
    if (c >= 6'd1 && c <= 6'd26) g = 8'd96 + 8'(c);
    if (c >= 6'd35 && c <= 6'd43) g = 8'd14 + 8'(c);
    return g;
  endfunction

  function automatic logic [7:0] status_char(input logic [1:0] m, input logic [2:0] i);
    logic [63:0] s;
    case (m)
      2'd1:    s = " compile";
      2'd2:    s = " idling ";
      2'd3:    s = " error  ";
      default: s = "        ";
    endcase
    s = s << {i, 3'b000};
    return s[63:56];
  endfunction

  assign btns = {clear_btn, bksp_btn, enter_btn, char_btn};
  assign fall = btn_q & ~btns;

  // Next-state and write generation; IDLE services one pending item per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    shown_d = shown_q;
    line_d  = line_q;
    pend_d  = pend_q | fall;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    off_d   = off_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    busy_d  = (state_q != IDLE);
    nx      = cx_q;
    ny      = cy_q;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (status_mode != shown_q) begin
          mode_d  = status_mode;
          cnt_d   = '0;
          state_d = STATUS;
        end else if (pend_q[B_CLR]) begin
          pend_d[B_CLR] = fall[B_CLR];
          cnt_d   = '0;
          state_d = CLEAR_ALL;
        end else if (pend_q[B_BKSP]) begin
          pend_d[B_BKSP] = fall[B_BKSP];
          if (cx_q != '0 || cy_q != '0) begin
            if (cx_q == '0) begin
              nx = LAST_COL;
              ny = cy_q - ROW_W'(1);
            end else begin
              nx = cx_q - COL_W'(1);
            end
            cx_d   = nx;
            cy_d   = ny;
            we_d   = 1'b1;
            addr_d = phys(ny, off_q, nx);
            data_d = 8'd32;
          end
        end else if (pend_q[B_ENT]) begin
          pend_d[B_ENT] = fall[B_ENT];
          we_d   = 1'b1;
          addr_d = phys(cy_q, off_q, cx_q);
          data_d = 8'd10;
          cx_d   = '0;
          adv    = 1'b1;
        end else if (pend_q[B_CHAR]) begin
          pend_d[B_CHAR] = fall[B_CHAR];
          we_d   = 1'b1;
          addr_d = phys(cy_q, off_q, cx_q);
          data_d = glyph(char_code);
          if (cx_q == LAST_COL) begin
            cx_d = '0;
            adv  = 1'b1;
          end else begin
            cx_d = cx_q + COL_W'(1);
          end
        end
        // At the bottom row, scroll and blank the row that becomes the new last line.
        if (adv) begin
          if (cy_q != LAST_ROW) begin
            cy_d = cy_q + ROW_W'(1);
          end else begin
            off_d   = (off_q == LAST_ROW) ? '0 : off_q + ROW_W'(1);
            line_d  = off_q;
            cnt_d   = '0;
            state_d = CLEAR_LINE;
          end
        end
      end
      STATUS: begin
        we_d   = 1'b1;
        addr_d = STATUS_BASE + cnt_q;
        data_d = status_char(mode_q, cnt_q[2:0]);
        if (cnt_q == STATUS_LAST) begin
          shown_d = mode_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      CLEAR_LINE: begin
        we_d   = 1'b1;
        addr_d = phys(line_q, '0, COL_W'(cnt_q));
        data_d = 8'd32;
        if (cnt_q == LINE_LAST) state_d = IDLE;
        else cnt_d = cnt_q + ADDR_W'(1);
      end
      CLEAR_ALL: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = 8'd32;
        if (cnt_q == CLEAR_LAST) begin
          cx_d    = '0;
          cy_d    = '0;
          off_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      shown_q <= '0;
      line_q  <= '0;
      btn_q   <= '0;
      pend_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      off_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      shown_q <= shown_d;
      line_q  <= line_d;
      btn_q   <= btns;
      pend_q  <= pend_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      off_q   <= off_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      busy_q  <= busy_d;
    end
  end

  assign tg_we      = we_q;
  assign tg_addr    = addr_q;
  assign tg_input   = data_q;
  assign row_offset = off_q;
  assign cursor_x   = cx_q;
  assign cursor_y   = cy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_terminal_scroll_controller.sv
// Directed bench for terminal_scroll_controller: logs every grid write and checks
// status refresh, wrap, scroll, backspace, full clear and asynchronous reset.
module tb_terminal_scroll_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_btn = 1'b0, enter_btn = 1'b0, bksp_btn = 1'b0, clear_btn = 1'b0;
  logic [5:0]  char_code = 6'd0;
  logic [1:0]  status_mode = 2'd0;
  logic        tg_we;
  logic [11:0] tg_addr;
  logic [7:0]  tg_input;
  logic [5:0]  row_offset;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        busy;

  int checks = 0;
  int passed = 0;
  int wa[$];
  int wd[$];
  int wb[$];

  terminal_scroll_controller dut (
    .pixel_clk_in(clk), .rst_in(rst_n),
    .char_btn(char_btn), .enter_btn(enter_btn), .bksp_btn(bksp_btn), .clear_btn(clear_btn),
    .char_code(char_code), .status_mode(status_mode),
    .tg_we(tg_we), .tg_addr(tg_addr), .tg_input(tg_input),
    .row_offset(row_offset), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n && tg_we) begin
      wa.push_back(int'(tg_addr));
      wd.push_back(int'(tg_input));
      wb.push_back(int'(busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    char_btn = 1'b0; enter_btn = 1'b0; bksp_btn = 1'b0; clear_btn = 1'b0;
    tick(2);
    clear_log();
    rst_n = 1'b1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: char_btn = v;
      1: enter_btn = v;
      2: bksp_btn = v;
      default: clear_btn = v;
    endcase
  endtask

  task automatic pulse(input int b);
    set_btn(b, 1'b1); tick(1);
    set_btn(b, 1'b0); tick(1);
  endtask

  task automatic wait_quiet();
    int q = 0;
    int t = 0;
    while (q < 4 && t < 6000) begin
      tick(1); t++;
      if (!busy && !tg_we) q++; else q = 0;
    end
    checks++;
    if (q < 4) $display("FAIL quiet_timeout: busy=%0d after %0d cycles, want idle", busy, t);
    else passed++;
  endtask

  task automatic test_reset();
    status_mode = 2'd0;
    rst_n = 1'b0;
    tick(2);
    checks++; if (tg_we !== 1'b0) $display("FAIL rst_we: got %0d want 0", tg_we); else passed++;
    checks++; if (tg_addr !== 12'd0) $display("FAIL rst_addr: got %0d want 0", tg_addr); else passed++;
    checks++; if (tg_input !== 8'd0) $display("FAIL rst_data: got %0d want 0", tg_input); else passed++;
    checks++; if (row_offset !== 6'd0) $display("FAIL rst_off: got %0d want 0", row_offset); else passed++;
    checks++; if (cursor_x !== 7'd0) $display("FAIL rst_cx: got %0d want 0", cursor_x); else passed++;
    checks++; if (cursor_y !== 6'd0) $display("FAIL rst_cy: got %0d want 0", cursor_y); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0d want 0", busy); else passed++;
    clear_log();
    rst_n = 1'b1;
    tick(10);
    checks++; if (wa.size() != 0) $display("FAIL rst_nowrite: got %0d writes want 0", wa.size()); else passed++;
  endtask

  task automatic test_status_char();
    int exp_s[8] = '{32, 99, 111, 109, 112, 105, 108, 101};
    int bad = 0;
    status_mode = 2'd0; do_reset();
    status_mode = 2'd1; char_code = 6'd1;
    pulse(0); wait_quiet();
    checks++; if (wa.size() != 9) $display("FAIL stat_count: got %0d want 9", wa.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wa.size() <= i || wd[i] != exp_s[i])
        $display("FAIL stat_data%0d: got %0d want %0d", i, (wa.size() > i) ? wd[i] : -1, exp_s[i]);
      else passed++;
      if (wa.size() <= i || wa[i] != 3192 + i) bad++;
    end
    checks++; if (bad != 0) $display("FAIL stat_addr: %0d wrong addresses, want 0", bad); else passed++;
    checks++;
    if (wa.size() < 9 || wa[8] != 0 || wd[8] != 97)
      $display("FAIL stat_char: got addr %0d data %0d want addr 0 data 97",
               (wa.size() > 8) ? wa[8] : -1, (wa.size() > 8) ? wd[8] : -1);
    else passed++;
    checks++; if (cursor_x !== 7'd1) $display("FAIL stat_cx: got %0d want 1", cursor_x); else passed++;
  endtask

  task automatic test_wrap();
    int bad = 0;
    status_mode = 2'd0; do_reset();
    char_code = 6'd35;
    repeat (76) begin pulse(0); wait_quiet(); end
    checks++; if (wa.size() != 76) $display("FAIL wrap_count: got %0d want 76", wa.size()); else passed++;
    foreach (wd[i]) if (wd[i] != 49) bad++;
    checks++; if (bad != 0) $display("FAIL wrap_data: %0d cells not 49, want 0", bad); else passed++;
    checks++;
    if (wa.size() == 0 || wa[wa.size()-1] != 75)
      $display("FAIL wrap_last: got %0d want 75", (wa.size() > 0) ? wa[wa.size()-1] : -1);
    else passed++;
    checks++; if (cursor_x !== 7'd0) $display("FAIL wrap_cx: got %0d want 0", cursor_x); else passed++;
    checks++; if (cursor_y !== 6'd1) $display("FAIL wrap_cy: got %0d want 1", cursor_y); else passed++;
  endtask

  task automatic test_scroll();
    int bad = 0;
    status_mode = 2'd0; do_reset();
    repeat (41) begin pulse(1); wait_quiet(); end
    checks++; if (cursor_y !== 6'd41) $display("FAIL scr_pre_cy: got %0d want 41", cursor_y); else passed++;
    clear_log();
    pulse(1); wait_quiet();
    checks++; if (wa.size() != 77) $display("FAIL scr_count: got %0d want 77", wa.size()); else passed++;
    checks++;
    if (wa.size() == 0 || wa[0] != 3116 || wd[0] != 10)
      $display("FAIL scr_lf: got addr %0d data %0d want 3116/10",
               (wa.size() > 0) ? wa[0] : -1, (wa.size() > 0) ? wd[0] : -1);
    else passed++;
    for (int i = 1; i < 77; i++)
      if (wa.size() <= i || wa[i] != i - 1 || wd[i] != 32 || wb[i] != 1) bad++;
    checks++; if (bad != 0) $display("FAIL scr_clearline: %0d bad cells, want 0", bad); else passed++;
    checks++; if (row_offset !== 6'd1) $display("FAIL scr_off: got %0d want 1", row_offset); else passed++;
    checks++; if (cursor_y !== 6'd41 || cursor_x !== 7'd0)
      $display("FAIL scr_cursor: got (%0d,%0d) want (0,41)", cursor_x, cursor_y); else passed++;
    clear_log(); char_code = 6'd2;
    pulse(0); wait_quiet();
    checks++;
    if (wa.size() != 1 || wa[0] != 0 || wd[0] != 98)
      $display("FAIL scr_wrapaddr: got %0d writes, first addr %0d want 1 write of 98 at 0",
               wa.size(), (wa.size() > 0) ? wa[0] : -1);
    else passed++;
    clear_log();
    pulse(1); wait_quiet();
    checks++;
    if (wa.size() != 77 || wa[0] != 1 || wd[0] != 10 || wa[1] != 76 || wa[76] != 151)
      $display("FAIL scr_second: got %0d writes, lf addr %0d, first clear %0d want 77/1/76",
               wa.size(), (wa.size() > 0) ? wa[0] : -1, (wa.size() > 1) ? wa[1] : -1);
    else passed++;
    checks++; if (row_offset !== 6'd2) $display("FAIL scr_off2: got %0d want 2", row_offset); else passed++;
  endtask

  task automatic test_bksp();
    status_mode = 2'd0; do_reset();
    repeat (3) begin pulse(1); wait_quiet(); end
    clear_log();
    pulse(2); wait_quiet();
    checks++;
    if (wa.size() != 1 || wa[0] != 227 || wd[0] != 32)
      $display("FAIL bksp_write: got %0d writes, addr %0d want 1 space at 227",
               wa.size(), (wa.size() > 0) ? wa[0] : -1);
    else passed++;
    checks++; if (cursor_x !== 7'd75 || cursor_y !== 6'd2)
      $display("FAIL bksp_cursor: got (%0d,%0d) want (75,2)", cursor_x, cursor_y); else passed++;
    do_reset();
    pulse(2); wait_quiet();
    checks++; if (wa.size() != 0) $display("FAIL bksp_origin: got %0d writes want 0", wa.size()); else passed++;
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0)
      $display("FAIL bksp_origin_cur: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); else passed++;
  endtask

  task automatic test_clear_all();
    int bad = 0;
    status_mode = 2'd0; do_reset();
    repeat (42) begin pulse(1); wait_quiet(); end
    char_code = 6'd1;
    pulse(0); wait_quiet();
    checks++; if (row_offset !== 6'd1) $display("FAIL clr_pre_off: got %0d want 1", row_offset); else passed++;
    clear_log();
    pulse(3);
    tick(20);
    char_code = 6'd3;
    pulse(0); tick(5); pulse(0);
    wait_quiet();
    checks++; if (wa.size() != 3193) $display("FAIL clr_count: got %0d want 3193", wa.size()); else passed++;
    for (int i = 0; i < 3192; i++)
      if (wa.size() <= i || wa[i] != i || wd[i] != 32) bad++;
    checks++; if (bad != 0) $display("FAIL clr_cells: %0d bad cells, want 0", bad); else passed++;
    checks++;
    if (wa.size() < 3193 || wa[3192] != 0 || wd[3192] != 99)
      $display("FAIL clr_char: got addr %0d data %0d want 0/99",
               (wa.size() > 3192) ? wa[3192] : -1, (wa.size() > 3192) ? wd[3192] : -1);
    else passed++;
    checks++; if (row_offset !== 6'd0) $display("FAIL clr_off: got %0d want 0", row_offset); else passed++;
    checks++; if (cursor_x !== 7'd1 || cursor_y !== 6'd0)
      $display("FAIL clr_cursor: got (%0d,%0d) want (1,0)", cursor_x, cursor_y); else passed++;
  endtask

  task automatic test_reset_mid();
    int exp_e[8] = '{32, 101, 114, 114, 111, 114, 32, 32};
    int bad = 0;
    status_mode = 2'd0; do_reset();
    char_code = 6'd1;
    pulse(0); wait_quiet();
    pulse(3); tick(100);
    checks++; if (busy !== 1'b1 || tg_we !== 1'b1)
      $display("FAIL mid_active: got busy %0d we %0d want 1/1", busy, tg_we); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (tg_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_rst_we_busy: got we %0d busy %0d want 0/0", tg_we, busy); else passed++;
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0 || row_offset !== 6'd0)
      $display("FAIL mid_rst_cursor: got (%0d,%0d) off %0d want 0", cursor_x, cursor_y, row_offset); else passed++;
    tick(3);
    clear_log();
    rst_n = 1'b1;
    tick(20);
    checks++; if (wa.size() != 0 || busy !== 1'b0)
      $display("FAIL mid_after: got %0d writes busy %0d want 0/0", wa.size(), busy); else passed++;
    status_mode = 2'd3; do_reset();
    wait_quiet();
    checks++; if (wa.size() != 8) $display("FAIL mid_status_count: got %0d want 8", wa.size()); else passed++;
    for (int i = 0; i < 8; i++)
      if (wa.size() <= i || wa[i] != 3192 + i || wd[i] != exp_e[i]) bad++;
    checks++; if (bad != 0) $display("FAIL mid_status_text: %0d bad cells, want 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_status_char();
    test_wrap();
    test_scroll();
    test_bksp();
    test_clear_all();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/terminal_scroll_controller.md
Name: terminal_scroll_controller

Overview:
Parametrised successor to the single-screen terminal controller. Turns debounced button events plus a glyph code into one-cell-per-cycle writes to the text-grid BRAM. Adds:
- auto-wrap at line end, and scrolling through a circular row offset with hardware line clearing
- full-screen clear
- a table-driven status field with four modes
- one-deep event queuing while busy

Sits between the gesture/button front end and the text-grid memory; the renderer consumes row_offset.

Parameters:
SCREEN_WIDTH, 76, columns per row.
SCREEN_HEIGHT, 44, total rows in the text grid.
STATUS_ROW, 42, physical row of the status field; editable rows are 0..STATUS_ROW-1 (TEXT_ROWS = STATUS_ROW).
STATUS_COL, 0, first column of the status field.
STATUS_LEN, 8, status field length in characters (1..8).

Ports:
pixel_clk_in  input  1  sole clock.
rst_in  input  1  asynchronous, active-low reset.
char_btn  input  1  level; a falling edge enters a character.
enter_btn  input  1  level; a falling edge is a newline.
bksp_btn  input  1  level; a falling edge is a backspace.
clear_btn  input  1  level; a falling edge clears the text area.
char_code  input  6  glyph code for char_btn.
status_mode  input  2  status text: 0 blank, 1 " compile", 2 " idling ", 3 " error  ".
tg_we  output  1  grid write strobe.
tg_addr  output  $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)  grid write address.
tg_input  output  8  ASCII write data.
row_offset  output  $clog2(TEXT_ROWS)  physical row holding logical row 0.
cursor_x  output  $clog2(SCREEN_WIDTH)  logical column.
cursor_y  output  $clog2(TEXT_ROWS)  logical row.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_in low, asynchronous) clears:
  - all outputs: tg_we, tg_addr, tg_input, row_offset, cursor_x, cursor_y, busy
  - all button history and pending flags
  - status_shown, which is set to 0
  - the FSM, which goes to IDLE
  Reset mid-operation abandons the sequence; no further writes occur.
- Edge detection: each button is registered every cycle. An edge is counted when prev=1 and current=0. A detected edge sets that button's pending flag; a second edge while the flag is set is dropped.
- Glyph map:
  - 0 → space (32)
  - 1-26 → a-z (97-122)
  - 27..34 → < > ( ) = , . # (60 62 40 41 61 44 46 35)
  - 35-43 → 1-9 (49-57); 44 → 0 (48)
  - 45..47 → | & ! (124 38 33)
  - 48 → LF (10)
  - 49-63 → space
- Physical address = ((cursor_y + row_offset) mod TEXT_ROWS)*SCREEN_WIDTH + col.
- tg_we is a one-cycle pulse, registered, together with tg_addr and tg_input. Outside write cycles, tg_addr and tg_input hold their last values.
- FSM states:
  - IDLE: services one pending item per cycle. Priority is status refresh (status_mode != status_shown) > clear > bksp > enter > char. Servicing an item clears its pending flag.
  - STATUS: writes STATUS_LEN cells at STATUS_ROW*SCREEN_WIDTH+STATUS_COL+i, i=0..STATUS_LEN-1, one per cycle. The mode is latched on entry, and status_shown is updated on exit.
  - CLEAR_LINE: writes space to SCREEN_WIDTH cells of one physical row, columns 0..W-1, one per cycle.
  - CLEAR_ALL: writes space to addresses 0..TEXT_ROWS*W-1, then sets cursor=(0,0) and row_offset=0. The status row is untouched.
- Char (IDLE, single cycle): writes the glyph at the cursor, then advances x. At x=W-1, x becomes 0 and the cursor takes a line advance.
- Enter: writes LF at the cursor, sets x=0, and takes a line advance.
- Line advance:
  - If y<TEXT_ROWS-1, y increments.
  - Otherwise y is held, row_offset increments mod TEXT_ROWS, and the FSM enters CLEAR_LINE on the new logical last row (the previous row_offset value).
- Backspace:
  - At (0,0) it is a no-op with no write.
  - Otherwise the cursor steps back first (x=0 → x=W-1, y-1), then writes space at the new position.
  - Backspace never un-scrolls.
- busy is asserted from the cycle after a multi-cycle state is entered until the cycle its last write is issued. Edges arriving during busy stay pending and are serviced on return to IDLE.

Test Plan:
- Reset, then status_mode=1, then release char_btn with char_code=1 → 8 status writes first: addr 3192..3199, data 32,99,111,109,112,105,108,101. Then write 97 at addr 0; cursor_x=1.
- 76 char presses with code 35 → last write at addr 75; cursor=(0,1); no LF written.
- Cursor at (0,41), row_offset=0, then enter → LF written at addr 41*76=3116. row_offset=1; cursor=(0,41); 76 space writes at addr 0..75; busy high throughout.
- Cursor (0,3), then bksp → space written at addr 2*76+75=227; cursor=(75,2). A bksp at (0,0) → no write.
- clear_btn pressed, then char_btn during the clear → 3192 space writes (0..3191); cursor and row_offset become 0; then a single char written at addr 0.
- Assert rst_in low mid CLEAR_ALL → tg_we, busy, row_offset and cursor are 0 immediately. After release, a status refresh occurs only if status_mode != 0.
